// File: rtl/tdc_code_histogram_pkg.sv
// rtl/tdc_code_histogram_pkg.sv - shared constants and FSM encoding for the TDC code histogram
// Purpose: default tap count, code/count widths and the histogram state type.
// Ports: none (package).
package tdc_code_histogram_pkg;

    localparam int TDC_NUM_TAPS = 240;
    localparam int TDC_BIN_W    = 9;
    localparam int TDC_CNT_W    = 16;
    localparam int TDC_OOR_W    = 16;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } hist_state_t;

endpackage

// File: rtl/tdc_hist_ram.sv
// rtl/tdc_hist_ram.sv - simple dual-port histogram bin RAM with registered read
// Purpose: DEPTH x DW storage, one write port and one registered read port.
// Ports: i_clk; i_we/i_waddr/i_wdata write port; i_raddr read address, o_rdata one cycle later.
//        A read of an address written in the same cycle returns the old contents.
module tdc_hist_ram #(
    parameter int DEPTH = 240,
    parameter int AW    = 8,
    parameter int DW    = 16
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/tdc_code_histogram.sv
// rtl/tdc_code_histogram.sv - code-density histogram of TDC fine codes with streamed readout
// Purpose: zero the bins, count valid fine codes per tap, then stream every bin out on sweep_done.
// Ports: i_clk, i_rst (async, active high), i_clear (restart pulse);
//        i_code_valid/i_code fine-code input; i_sweep_done level, rising edge ends accumulation;
//        o_rd_valid/i_rd_ready/o_rd_bin/o_rd_count/o_rd_last readout stream;
//        o_busy (CLEAR or DRAIN), o_oor_count (out-of-range codes), o_sat_flag (sticky saturation).
module tdc_code_histogram
    import tdc_code_histogram_pkg::*;
#(
    parameter int NUM_TAPS = TDC_NUM_TAPS,
    parameter int BIN_W    = TDC_BIN_W,
    parameter int CNT_W    = TDC_CNT_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_code_valid,
    input  logic [BIN_W-1:0]     i_code,
    input  logic                 i_sweep_done,
    output logic                 o_rd_valid,
    input  logic                 i_rd_ready,
    output logic [BIN_W-1:0]     o_rd_bin,
    output logic [CNT_W-1:0]     o_rd_count,
    output logic                 o_rd_last,
    output logic                 o_busy,
    output logic [TDC_OOR_W-1:0] o_oor_count,
    output logic                 o_sat_flag
);

    localparam int RAM_AW = $clog2(NUM_TAPS);
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_TAPS - 1);
    localparam logic [BIN_W-1:0] TAPS     = BIN_W'(NUM_TAPS);

    hist_state_t      r_state;
    logic [BIN_W-1:0] r_clr_addr;
    logic             r_sweep_q;
    logic             r_drain_pend;
    // s1: read issued last cycle; s2: write this cycle; s3: write committed last cycle
    logic             r_s1_valid, r_s2_valid, r_s3_valid;
    logic [BIN_W-1:0] r_s1_bin, r_s2_bin, r_s3_bin;
    logic [CNT_W-1:0] r_s2_data, r_s3_data;
    logic [BIN_W-1:0] r_fetch_addr;
    logic             r_fetch_ok;

    logic             w_sweep_rise, w_accept, w_in_range, w_hit, w_oor;
    logic [CNT_W-1:0] w_rdata, w_cur, w_next;
    logic [CNT_W:0]   w_sum;
    logic             w_sat, w_load, w_pop;
    logic [BIN_W-1:0] w_fetch_next, w_raddr, w_waddr;
    logic             w_we;
    logic [CNT_W-1:0] w_wdata;

    assign w_sweep_rise = i_sweep_done & ~r_sweep_q;
    // After the sweep edge only the code of the edge cycle itself is still taken.
    assign w_accept   = (r_state == ST_ACCUM) && !r_drain_pend && i_code_valid;
    assign w_in_range = i_code < TAPS;
    assign w_hit      = w_accept && w_in_range;
    assign w_oor      = w_accept && !w_in_range;

    // The RAM read misses the two youngest updates; take them from the pipeline instead.
    assign w_cur  = (r_s2_valid && r_s2_bin == r_s1_bin) ? r_s2_data :
                    (r_s3_valid && r_s3_bin == r_s1_bin) ? r_s3_data : w_rdata;
    assign w_sum  = {1'b0, w_cur} + (CNT_W + 1)'(1);
    assign w_sat  = w_sum[CNT_W];
    assign w_next = w_sat ? w_cur : w_sum[CNT_W-1:0];

    // Output slot is refilled from the prefetched word whenever it is empty or being taken.
    assign w_pop        = o_rd_valid && i_rd_ready;
    assign w_load       = (r_state == ST_DRAIN) && r_fetch_ok && (r_fetch_addr < TAPS) &&
                          (!o_rd_valid || i_rd_ready);
    assign w_fetch_next = w_load ? r_fetch_addr + BIN_W'(1) : r_fetch_addr;

    always_comb begin
        w_raddr = '0;
        if (r_state == ST_DRAIN) begin
            // Present the address that will be current next cycle so no bubble appears.
            if (w_fetch_next < TAPS) w_raddr = w_fetch_next;
        end else if (w_in_range) begin
            w_raddr = i_code;
        end
    end

    always_comb begin
        w_we    = r_s2_valid;
        w_waddr = r_s2_bin;
        w_wdata = r_s2_data;
        if (r_state == ST_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_clr_addr;
            w_wdata = '0;
        end
    end

    tdc_hist_ram #(
        .DEPTH (NUM_TAPS),
        .AW    (RAM_AW),
        .DW    (CNT_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (w_waddr[RAM_AW-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr[RAM_AW-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_CLEAR;
            r_clr_addr   <= '0;
            r_sweep_q    <= 1'b0;
            r_drain_pend <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_bin     <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_bin     <= '0;
            r_s2_data    <= '0;
            r_s3_valid   <= 1'b0;
            r_s3_bin     <= '0;
            r_s3_data    <= '0;
            r_fetch_addr <= '0;
            r_fetch_ok   <= 1'b0;
            o_rd_valid   <= 1'b0;
            o_rd_bin     <= '0;
            o_rd_count   <= '0;
            o_rd_last    <= 1'b0;
            o_busy       <= 1'b1;
            o_oor_count  <= '0;
            o_sat_flag   <= 1'b0;
        end else begin
            r_sweep_q  <= i_sweep_done;
            r_s1_valid <= w_hit;
            r_s1_bin   <= i_code;
            r_s2_valid <= r_s1_valid;
            r_s2_bin   <= r_s1_bin;
            r_s2_data  <= w_next;
            r_s3_valid <= r_s2_valid;
            r_s3_bin   <= r_s2_bin;
            r_s3_data  <= r_s2_data;
            if (r_s1_valid && w_sat) o_sat_flag <= 1'b1;
            if (w_oor && o_oor_count != '1) o_oor_count <= o_oor_count + TDC_OOR_W'(1);

            if (i_clear) begin
                r_state      <= ST_CLEAR;
                r_clr_addr   <= '0;
                r_drain_pend <= 1'b0;
                r_s1_valid   <= 1'b0;
                r_s2_valid   <= 1'b0;
                r_s3_valid   <= 1'b0;
                o_oor_count  <= '0;
                o_sat_flag   <= 1'b0;
                o_rd_valid   <= 1'b0;
                o_rd_last    <= 1'b0;
                o_busy       <= 1'b1;
            end else begin
                case (r_state)
                    ST_CLEAR: begin
                        r_clr_addr <= r_clr_addr + BIN_W'(1);
                        if (r_clr_addr == LAST_BIN) begin
                            r_state    <= ST_ACCUM;
                            r_clr_addr <= '0;
                            o_busy     <= 1'b0;
                        end
                    end
                    ST_ACCUM: begin
                        if (w_sweep_rise && !r_drain_pend) r_drain_pend <= 1'b1;
                        // s2 writes during this cycle, so a drain read next cycle sees it.
                        if (r_drain_pend && !r_s1_valid) begin
                            r_state      <= ST_DRAIN;
                            r_drain_pend <= 1'b0;
                            r_fetch_addr <= '0;
                            r_fetch_ok   <= 1'b0;
                            o_busy       <= 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        r_fetch_ok   <= 1'b1;
                        r_fetch_addr <= w_fetch_next;
                        if (w_load) begin
                            o_rd_valid <= 1'b1;
                            o_rd_bin   <= r_fetch_addr;
                            o_rd_count <= w_rdata;
                            o_rd_last  <= (r_fetch_addr == LAST_BIN);
                        end else if (w_pop) begin
                            o_rd_valid <= 1'b0;
                        end
                        if (w_pop && o_rd_last) begin
                            r_state    <= ST_DONE;
                            o_rd_valid <= 1'b0;
                            o_rd_last  <= 1'b0;
                            o_busy     <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdc_code_histogram.sv
// tb/tb_tdc_code_histogram.sv - self-checking bench for tdc_code_histogram
module tb_tdc_code_histogram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        code_valid = 1'b0;
    logic [8:0]  code = '0;
    logic        sweep_done = 1'b0;
    logic        rd_ready = 1'b0;
    logic        rd_valid, rd_last, busy, sat_flag;
    logic [8:0]  rd_bin;
    logic [15:0] rd_count, oor_count;

    int n_checks = 0;
    int n_fail   = 0;

    int m_bins[240];
    int m_oor;
    bit m_sat;

    int q_bin[$];
    int q_cnt[$];
    bit q_last[$];
    int drain_stall_err, drain_cycles;
    bit drain_timeout;

    always #5 clk = ~clk;

    tdc_code_histogram dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_clear      (clear),
        .i_code_valid (code_valid),
        .i_code       (code),
        .i_sweep_done (sweep_done),
        .o_rd_valid   (rd_valid),
        .i_rd_ready   (rd_ready),
        .o_rd_bin     (rd_bin),
        .o_rd_count   (rd_count),
        .o_rd_last    (rd_last),
        .o_busy       (busy),
        .o_oor_count  (oor_count),
        .o_sat_flag   (sat_flag)
    );

    task automatic model_reset();
        for (int i = 0; i < 240; i++) m_bins[i] = 0;
        m_oor = 0;
        m_sat = 0;
    endtask

    task automatic send_code(input int c);
        @(negedge clk);
        code_valid = 1'b1;
        code = 9'(c);
        if (c < 240) begin
            if (m_bins[c] == 65535) m_sat = 1;
            else m_bins[c] = m_bins[c] + 1;
        end else if (m_oor < 65535) begin
            m_oor = m_oor + 1;
        end
    endtask

    task automatic end_codes();
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    // Returns the number of consecutive busy cycles observed starting now.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_clear(output int nbusy);
        @(negedge clk);
        code_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        count_busy(nbusy);
    endtask

    // Lower sweep_done for one cycle, then raise it (optionally with a code on the rising cycle).
    task automatic sweep_rise(input bit with_code, input int c);
        @(negedge clk);
        code_valid = 1'b0;
        sweep_done = 1'b0;
        if (with_code) begin
            send_code(c);
        end else begin
            @(negedge clk);
        end
        sweep_done = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    task automatic run_drain(input int ready_pct, input int clear_at);
        int cyc, first;
        bit stalled;
        int sb, sc;
        q_bin.delete(); q_cnt.delete(); q_last.delete();
        drain_stall_err = 0; drain_timeout = 0; drain_cycles = 0;
        cyc = 0; first = -1; stalled = 0; sb = 0; sc = 0;
        while (1) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (cyc > 3000) begin drain_timeout = 1; break; end
            if (stalled && (!rd_valid || int'(rd_bin) != sb || int'(rd_count) != sc))
                drain_stall_err++;
            rd_ready = ($urandom_range(0, 99) < ready_pct);
            if (clear_at >= 0 && rd_valid && int'(rd_bin) == clear_at) begin
                clear = 1'b1;
                @(negedge clk);
                clear = 1'b0;
                model_reset();
                break;
            end
            if (rd_valid && rd_ready) begin
                q_bin.push_back(int'(rd_bin));
                q_cnt.push_back(int'(rd_count));
                q_last.push_back(rd_last);
                if (first < 0) first = cyc;
                drain_cycles = cyc - first + 1;
                if (rd_last) begin @(negedge clk); break; end
            end
            stalled = rd_valid && !rd_ready;
            sb = int'(rd_bin);
            sc = int'(rd_count);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        int nb;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || rd_valid !== 1'b0 || rd_last !== 1'b0 || oor_count !== 16'd0 || sat_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values busy=%b rd_valid=%b rd_last=%b oor=%0d sat=%b required busy=1 others 0",
                     busy, rd_valid, rd_last, oor_count, sat_flag);
        end
        rst = 1'b0;
        model_reset();
        count_busy(nb);
        n_checks++;
        if (nb != 240) begin n_fail++; $display("FAIL reset_busy_len got %0d required 240", nb); end
        send_code(300);
        end_codes();
        n_checks++;
        if (oor_count !== 16'd1) begin n_fail++; $display("FAIL pre_rst_oor got %0d required 1", oor_count); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (oor_count !== 16'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL async_rst got oor=%0d busy=%b required oor=0 busy=1", oor_count, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        count_busy(nb);
        n_checks++;
        if (nb != 240) begin n_fail++; $display("FAIL rst_again_busy_len got %0d required 240", nb); end
        sweep_rise(0, 0);
        run_drain(100, -1);
        n_checks++;
        if (drain_timeout || q_bin.size() != 240) begin
            n_fail++; $display("FAIL empty_drain_words got %0d required 240", q_bin.size());
        end
        for (int i = 0; i < q_bin.size() && i < 240; i++) begin
            n_checks++;
            if (q_bin[i] != i || q_cnt[i] != 0 || q_last[i] != (i == 239)) begin
                n_fail++;
                $display("FAIL empty_drain[%0d] got bin=%0d cnt=%0d last=%b required bin=%0d cnt=0", i, q_bin[i], q_cnt[i], q_last[i], i);
            end
        end
    endtask

    task automatic test_forwarding();
        int nb;
        int seq[5] = '{5, 5, 5, 6, 5};
        do_clear(nb);
        n_checks++;
        if (nb != 240) begin n_fail++; $display("FAIL fwd_clear_len got %0d required 240", nb); end
        foreach (seq[i]) send_code(seq[i]);
        end_codes();
        sweep_rise(0, 0);
        run_drain(100, -1);
        n_checks++;
        if (drain_timeout || q_bin.size() != 240 || drain_cycles != 240 || drain_stall_err != 0) begin
            n_fail++;
            $display("FAIL fwd_drain got words=%0d span=%0d stall_err=%0d required 240/240/0", q_bin.size(), drain_cycles, drain_stall_err);
        end
        n_checks++;
        if (m_bins[5] != 4 || m_bins[6] != 1) begin n_fail++; $display("FAIL fwd_model got %0d,%0d required 4,1", m_bins[5], m_bins[6]); end
        for (int i = 0; i < q_bin.size() && i < 240; i++) begin
            n_checks++;
            if (q_bin[i] != i || q_cnt[i] != m_bins[i] || q_last[i] != (i == 239)) begin
                n_fail++;
                $display("FAIL fwd_bin[%0d] got bin=%0d cnt=%0d last=%b required cnt=%0d", i, q_bin[i], q_cnt[i], q_last[i], m_bins[i]);
            end
        end
        n_checks++;
        if (rd_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL fwd_done got rd_valid=%b busy=%b required 0 0", rd_valid, busy); end
    endtask

    task automatic test_oor_sat();
        int nb;
        do_clear(nb);
        send_code(240);
        send_code(511);
        end_codes();
        n_checks++;
        if (oor_count !== 16'(m_oor) || m_oor != 2) begin n_fail++; $display("FAIL oor_count got %0d required 2", oor_count); end
        n_checks++;
        if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_early got %b required 0", sat_flag); end
        for (int i = 0; i < 70000; i++) send_code(0);
        send_code(17);
        end_codes();
        n_checks++;
        if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_flag got %b required 1", sat_flag); end
        sweep_rise(0, 0);
        run_drain(100, -1);
        n_checks++;
        if (drain_timeout || q_bin.size() != 240) begin n_fail++; $display("FAIL sat_drain_words got %0d required 240", q_bin.size()); end
        for (int i = 0; i < q_bin.size() && i < 240; i++) begin
            n_checks++;
            if (q_bin[i] != i || q_cnt[i] != m_bins[i]) begin
                n_fail++;
                $display("FAIL sat_bin[%0d] got bin=%0d cnt=%0d required cnt=%0d", i, q_bin[i], q_cnt[i], m_bins[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int nb, c;
        do_clear(nb);
        n_checks++;
        if (sat_flag !== 1'b0 || oor_count !== 16'd0) begin n_fail++; $display("FAIL clear_status got sat=%b oor=%0d required 0 0", sat_flag, oor_count); end
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                code_valid = 1'b0;
            end else begin
                // Mix a narrow range (same-bin neighbours) with the full code space.
                c = ($urandom_range(0, 1) == 0) ? int'($urandom_range(10, 12)) : int'($urandom_range(0, 270));
                send_code(c);
            end
        end
        end_codes();
        sweep_rise(0, 0);
        run_drain(45, -1);
        n_checks++;
        if (drain_timeout || q_bin.size() != 240 || drain_stall_err != 0) begin
            n_fail++; $display("FAIL bp_drain got words=%0d stall_err=%0d required 240 0", q_bin.size(), drain_stall_err);
        end
        n_checks++;
        if (oor_count !== 16'(m_oor)) begin n_fail++; $display("FAIL bp_oor got %0d required %0d", oor_count, m_oor); end
        for (int i = 0; i < q_bin.size() && i < 240; i++) begin
            n_checks++;
            if (q_bin[i] != i || q_cnt[i] != m_bins[i] || q_last[i] != (i == 239)) begin
                n_fail++;
                $display("FAIL bp_bin[%0d] got bin=%0d cnt=%0d last=%b required cnt=%0d", i, q_bin[i], q_cnt[i], q_last[i], m_bins[i]);
            end
        end
    endtask

    task automatic test_clear_mid_drain();
        int nb, nlast;
        do_clear(nb);
        for (int i = 0; i < 60; i++) send_code(int'($urandom_range(0, 239)));
        end_codes();
        sweep_rise(0, 0);
        run_drain(100, 100);
        n_checks++;
        if (drain_timeout || rd_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL abort_state got timeout=%b rd_valid=%b busy=%b required 0 0 1", drain_timeout, rd_valid, busy);
        end
        nlast = 0;
        foreach (q_last[i]) if (q_last[i]) nlast++;
        n_checks++;
        if (nlast != 0 || q_bin.size() != 100) begin n_fail++; $display("FAIL abort_words got words=%0d lasts=%0d required 100 0", q_bin.size(), nlast); end
        count_busy(nb);
        n_checks++;
        if (nb != 240) begin n_fail++; $display("FAIL abort_clear_len got %0d required 240", nb); end
        send_code(9); send_code(9); send_code(200);
        end_codes();
        sweep_rise(0, 0);
        run_drain(100, -1);
        n_checks++;
        if (drain_timeout || q_bin.size() != 240) begin n_fail++; $display("FAIL fresh_words got %0d required 240", q_bin.size()); end
        for (int i = 0; i < q_bin.size() && i < 240; i++) begin
            n_checks++;
            if (q_bin[i] != i || q_cnt[i] != m_bins[i]) begin
                n_fail++;
                $display("FAIL fresh_bin[%0d] got bin=%0d cnt=%0d required cnt=%0d", i, q_bin[i], q_cnt[i], m_bins[i]);
            end
        end
    endtask

    task automatic test_sweep_held();
        int nb, nact;
        // sweep_done is still high from the previous drain: leaving CLEAR must not start a drain.
        do_clear(nb);
        repeat (20) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL level_no_drain got busy=%b rd_valid=%b required 0 0", busy, rd_valid); end
        @(negedge clk); sweep_done = 1'b0;
        @(negedge clk); sweep_done = 1'b1; clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        model_reset();
        count_busy(nb);
        repeat (20) @(negedge clk);
        n_checks++;
        if (nb != 240 || busy !== 1'b0 || rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL clear_beats_edge got busy_len=%0d busy=%b rd_valid=%b required 240 0 0", nb, busy, rd_valid);
        end
        send_code(3); send_code(7);
        end_codes();
        sweep_rise(1, 7);
        run_drain(100, -1);
        n_checks++;
        if (drain_timeout || q_bin.size() != 240) begin n_fail++; $display("FAIL held_words got %0d required 240", q_bin.size()); end
        for (int i = 0; i < q_bin.size() && i < 240; i++) begin
            n_checks++;
            if (q_bin[i] != i || q_cnt[i] != m_bins[i]) begin
                n_fail++;
                $display("FAIL held_bin[%0d] got bin=%0d cnt=%0d required cnt=%0d", i, q_bin[i], q_cnt[i], m_bins[i]);
            end
        end
        nact = 0;
        rd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            code_valid = 1'b1;
            code = 9'(i);
            if (rd_valid || busy) nact++;
        end
        code_valid = 1'b0;
        rd_ready = 1'b0;
        n_checks++;
        if (nact != 0) begin n_fail++; $display("FAIL done_holds got %0d active cycles required 0", nact); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_forwarding();
        test_oor_sat();
        test_backpressure();
        test_clear_mid_drain();
        test_sweep_held();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
